pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core. It replaces the free-running stage-enable registers with per-stage enables and flushes, and extends plain EX/MEM and MEM/WB forwarding with four additions: load-use stalls, a multi-cycle multiplier stall counter, branch/jump flushes resolved in MEM, and a forwarding-disabled mode. It sits beside the forwarding muxes and drives the PC enable and the IF/ID, ID/EX, EX/MEM and MEM/WB register controls.

Parameters:
REG_ADDR_W, 5, register-index width
MUL_LAT, 3, cycles a multiply occupies EX (≥1; 1 means no stall)
FWD_EN, 1, 1 = forward from MEM/WB stages; 0 = stall on every RAW hazard instead
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
enable  in  1  run request, sampled each cycle
rs1_id, rs2_id  in  REG_ADDR_W  source registers of the instruction in ID
uses_rs1_id, uses_rs2_id  in  1  ID instruction actually reads rs1/rs2
rs1_ex, rs2_ex, rd_ex  in  REG_ADDR_W  EX-stage register fields
reg_write_ex, mem_read_ex, is_mul_ex  in  1  EX-stage controls
rd_mem, rd_wb  in  REG_ADDR_W  destinations in MEM and WB
reg_write_mem, reg_write_wb  in  1  write enables in MEM and WB
take_branch_mem  in  1  taken branch or jump resolved in MEM
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1  load zero (NOP) bubble when enable is also 1
forward_a, forward_b  out  2  ALU operand select
mul_busy  out  1  multiply stall in progress
stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- run register: reset 0; each cycle run <= enable. Every *_en is 0 whenever run=0.
- Reset values: all enables 0, all flushes 0, mul_busy 0, stall_cycles 0, multiply counter 0.
- Forwarding (combinational, independent of run), shown for operand a; b uses rs2_ex:
  - 2'b10 if reg_write_mem & rd_mem≠0 & rd_mem==rs1_ex;
  - else 2'b01 if reg_write_wb & rd_wb≠0 & rd_wb==rs1_ex;
  - else 2'b00.
  - If FWD_EN=0, both selects are held at 2'b00.
- hit(rd, we) = we & rd≠0 & ((uses_rs1_id & rd==rs1_id) | (uses_rs2_id & rd==rs2_id)).
- Load-use stall (FWD_EN=1): mem_read_ex & hit(rd_ex, reg_write_ex).
- RAW stall (FWD_EN=0): hit against the EX, MEM or WB producer. The register file has no write-through, so a WB match also stalls.
- A load-use or RAW stall lasts one cycle per occurrence:
  - pc_en=0, if_id_en=0;
  - id_ex_en=1 with id_ex_flush=1 (bubble);
  - ex_mem_en=mem_wb_en=1.
- Multiply counter cnt, width clog2(MUL_LAT+1):
  - mul_stall = run & is_mul_ex & (cnt ≠ MUL_LAT−1).
  - While mul_stall: cnt increments; pc_en=if_id_en=id_ex_en=0; ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1; mul_busy=1.
  - Advance cycle: is_mul_ex & cnt==MUL_LAT−1. EX advances normally and cnt clears to 0.
  - A back-to-back multiply restarts from 0. With MUL_LAT=1 it never stalls.
- Branch flush: take_branch_mem & run.
  - All enables 1; if_id_flush, id_ex_flush and ex_mem_flush all 1; pc_en=1 so the PC loads the target.
  - cnt clears to 0 and no stall is asserted that cycle.
- Priority: branch flush > multiply stall > load-use/RAW stall.
  - A multiply stall holds ID/EX, so no id_ex_flush is issued while it is active.
- stall_cycles: increments on any cycle where a multiply or load-use/RAW stall is asserted; saturates at all-ones; flush cycles are not counted.
- enable dropped mid-multiply: enables go to 0 next cycle, cnt holds, and the operation resumes when enable returns.
- arst_n mid-operation: asynchronous return to the reset values.

Decomposition:
- Shared package cpu_pkg holds the forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, plus the default REG_ADDR_W.
- One sub-module, mul_stall_counter (params MUL_LAT), with inputs clk, arst_n, run, is_mul, flush and outputs mul_stall, cnt.

Test Plan:
- Reset, then enable=1: enables stay 0 for the cycle enable is first sampled, all are 1 from the next cycle; flushes 0; stall_cycles=0.
- Forwarding with rs1_ex=5:
  - rd_mem=5 with write → forward_a=10;
  - rd_mem=6, rd_wb=5 with write → 01;
  - rd_mem=0 and rd_wb=0 → 00;
  - rs2_ex=5 with both rd_mem and rd_wb =5 → forward_b=10.
- Load x7 in EX, ID uses rs2=7 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all clear; stall_cycles=1.
- MUL_LAT=3, multiply in EX → 2 cycles of mul_busy=1 and ex_mem_flush=1, advance on the 3rd; stall_cycles +=2; an immediate second multiply gives 2 more stall cycles.
- take_branch_mem on the 1st multiply-stall cycle → all three flushes=1, pc_en=1, mul_busy=0 next cycle, cnt=0.
- FWD_EN=0, ID reads x3, producer x3 in EX → stalls 3 consecutive cycles (EX, MEM, WB), forward_a stays 00, stall_cycles=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: forwarding-mux encodings and the
// default register-index width.
package cpu_pkg;

    localparam int unsigned DEF_REG_ADDR_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/mul_stall_counter.sv
// Counts the cycles a multiply has occupied EX and requests a stall until the
// last latency cycle; a branch flush or a non-multiply in EX clears the count.
module mul_stall_counter #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic                             run,
    input  logic                             is_mul,
    input  logic                             flush,
    output logic                             mul_stall,
    output logic [$clog2(MUL_LAT+1)-1:0]     cnt
);

    localparam int unsigned CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_LAT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // While stopped the count holds so a paused multiply resumes where it left off.
    always_comb begin
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else if (run) begin
            if (is_mul && (cnt_q != LAST)) begin
                mul_stall = 1'b1;
                cnt_d     = cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit: stage enables/flushes for load-use, RAW,
// multi-cycle multiply and MEM-resolved branches, plus ALU forwarding selects.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned MUL_LAT    = 3,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  uses_rs1_id,
    input  logic                  uses_rs2_id,
    input  logic [REG_ADDR_W-1:0] rs1_ex,
    input  logic [REG_ADDR_W-1:0] rs2_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  reg_write_ex,
    input  logic                  mem_read_ex,
    input  logic                  is_mul_ex,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  reg_write_mem,
    input  logic                  reg_write_wb,
    input  logic                  take_branch_mem,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output fwd_sel_t              forward_a,
    output fwd_sel_t              forward_b,
    output logic                  mul_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int unsigned MUL_CW = $clog2(MUL_LAT + 1);

    logic              run_q;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              branch, mul_stall, haz, hz_stall, stall_any;
    logic              hit_ex, hit_mem, hit_wb;
    logic [MUL_CW-1:0] mul_cnt;

    function automatic logic hit(input logic [REG_ADDR_W-1:0] rd, input logic we,
                                 input logic [REG_ADDR_W-1:0] s1, input logic u1,
                                 input logic [REG_ADDR_W-1:0] s2, input logic u2);
        return we && (rd != '0) && ((u1 && (rd == s1)) || (u2 && (rd == s2)));
    endfunction

    function automatic fwd_sel_t fwd(input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rdm, input logic wem,
                                     input logic [REG_ADDR_W-1:0] rdw, input logic wew);
        if (wem && (rdm != '0) && (rdm == rs)) return FWD_MEM;
        if (wew && (rdw != '0) && (rdw == rs)) return FWD_WB;
        return FWD_RF;
    endfunction

    assign hit_ex  = hit(rd_ex,  reg_write_ex,  rs1_id, uses_rs1_id, rs2_id, uses_rs2_id);
    assign hit_mem = hit(rd_mem, reg_write_mem, rs1_id, uses_rs1_id, rs2_id, uses_rs2_id);
    assign hit_wb  = hit(rd_wb,  reg_write_wb,  rs1_id, uses_rs1_id, rs2_id, uses_rs2_id);

    // Without forwarding the register file has no write-through, so WB producers stall too.
    assign haz      = (FWD_EN != 0) ? (mem_read_ex && hit_ex) : (hit_ex || hit_mem || hit_wb);
    assign hz_stall = run_q && haz;
    assign branch   = run_q && take_branch_mem;

    mul_stall_counter #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_cnt (
        .clk       (clk),
        .arst_n    (arst_n),
        .run       (run_q),
        .is_mul    (is_mul_ex),
        .flush     (branch),
        .mul_stall (mul_stall),
        .cnt       (mul_cnt)
    );

    // Priority: branch flush, then multiply stall, then load-use/RAW bubble.
    always_comb begin
        pc_en        = run_q;
        if_id_en     = run_q;
        id_ex_en     = run_q;
        ex_mem_en    = run_q;
        mem_wb_en    = run_q;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (branch) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (mul_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (hz_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (FWD_EN != 0) begin
            forward_a = fwd(rs1_ex, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
            forward_b = fwd(rs2_ex, rd_mem, reg_write_mem, rd_wb, reg_write_wb);
        end
    end

    assign stall_any = (mul_stall || hz_stall) && !branch;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_any && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            run_q          <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            run_q          <= enable;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mul_busy     = mul_stall;
    assign stall_cycles = stall_cycles_q;

    mul_cnt_range: assert property (@(posedge clk) disable iff (!arst_n)
                                    mul_cnt <= MUL_CW'(MUL_LAT - 1));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them against one of two differently configured units.
module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] RUN  = 5'b11111;
    localparam logic [4:0] OFF  = 5'b00000;
    localparam logic [4:0] LU   = 5'b00111;
    localparam logic [4:0] MS   = 5'b00011;
    localparam logic [2:0] NF   = 3'b000;
    localparam logic [2:0] F_LU = 3'b010;
    localparam logic [2:0] F_MS = 3'b001;
    localparam logic [2:0] F_BR = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst_n, enable;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       uses_rs1_id, uses_rs2_id, reg_write_ex, mem_read_ex, is_mul_ex;
    logic       reg_write_mem, reg_write_wb, take_branch_mem;

    logic        pc_a, ifid_a, idex_a, exmem_a, memwb_a, fl1_a, fl2_a, fl3_a, busy_a;
    logic [1:0]  fa_a, fb_a;
    logic [31:0] sc_a;
    logic        pc_z, ifid_z, idex_z, exmem_z, memwb_z, fl1_z, fl2_z, fl3_z, busy_z;
    logic [1:0]  fa_z, fb_z;
    logic [1:0]  sc_z;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(3), .FWD_EN(1), .CNT_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .is_mul_ex(is_mul_ex),
        .rd_mem(rd_mem), .rd_wb(rd_wb), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .take_branch_mem(take_branch_mem),
        .pc_en(pc_a), .if_id_en(ifid_a), .id_ex_en(idex_a), .ex_mem_en(exmem_a), .mem_wb_en(memwb_a),
        .if_id_flush(fl1_a), .id_ex_flush(fl2_a), .ex_mem_flush(fl3_a),
        .forward_a(fa_a), .forward_b(fb_a), .mul_busy(busy_a), .stall_cycles(sc_a)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(1), .FWD_EN(0), .CNT_W(2)) dut_nofwd (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .is_mul_ex(is_mul_ex),
        .rd_mem(rd_mem), .rd_wb(rd_wb), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .take_branch_mem(take_branch_mem),
        .pc_en(pc_z), .if_id_en(ifid_z), .id_ex_en(idex_z), .ex_mem_en(exmem_z), .mem_wb_en(memwb_z),
        .if_id_flush(fl1_z), .id_ex_flush(fl2_z), .ex_mem_flush(fl3_z),
        .forward_a(fa_z), .forward_b(fb_z), .mul_busy(busy_z), .stall_cycles(sc_z)
    );

    typedef struct {
        bit          sel;
        string       nm;
        logic [44:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Expected vector layout: {en[4:0] pc..mem_wb, flush[2:0] if_id..ex_mem, fa, fb, busy, sc[31:0]}
    function automatic logic [44:0] pk(input logic [4:0] en, input logic [2:0] fl,
                                       input logic busy, input logic [31:0] sc,
                                       input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00);
        return {en, fl, fa, fb, busy, sc};
    endfunction

    task automatic push(input bit sel, input string nm, input logic [44:0] v);
        exp_t e;
        e.sel = sel;
        e.nm  = nm;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0;
        uses_rs1_id = 1'b0; uses_rs2_id = 1'b0;
        reg_write_ex = 1'b0; mem_read_ex = 1'b0; is_mul_ex = 1'b0;
        reg_write_mem = 1'b0; reg_write_wb = 1'b0; take_branch_mem = 1'b0;
    endtask

    exp_t        cur;
    logic [44:0] act;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.sel)
                act = {pc_z, ifid_z, idex_z, exmem_z, memwb_z, fl1_z, fl2_z, fl3_z,
                       fa_z, fb_z, busy_z, 32'(sc_z)};
            else
                act = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, fl1_a, fl2_a, fl3_a,
                       fa_a, fb_a, busy_a, sc_a};
            n_cmp++;
            if (act !== cur.v) begin
                n_err++;
                $display("FAIL %s: got en=%b fl=%b fa=%b fb=%b busy=%b sc=%0d, required en=%b fl=%b fa=%b fb=%b busy=%b sc=%0d",
                         cur.nm, act[44:40], act[39:37], act[36:35], act[34:33], act[32], act[31:0],
                         cur.v[44:40], cur.v[39:37], cur.v[36:35], cur.v[34:33], cur.v[32], cur.v[31:0]);
            end
        end
    end

    initial begin
        int wait_c;
        wait_c = 0;
        arst_n = 1'b0;
        enable = 1'b0;
        idle();

        tick(); push(0, "reset", pk(OFF, NF, 0, 0));
        tick(); arst_n = 1'b1; push(0, "post_reset", pk(OFF, NF, 0, 0));
        tick(); enable = 1'b1; push(0, "enable_first_cycle", pk(OFF, NF, 0, 0));
        tick(); push(0, "run_enabled", pk(RUN, NF, 0, 0));

        // forwarding patterns
        tick(); rs1_ex = 5; rd_mem = 5; reg_write_mem = 1; push(0, "fwd_a_mem", pk(RUN, NF, 0, 0, 2'b10));
        tick(); rd_mem = 6; rd_wb = 5; reg_write_wb = 1;   push(0, "fwd_a_wb", pk(RUN, NF, 0, 0, 2'b01));
        tick(); rd_mem = 0; rd_wb = 0;                     push(0, "fwd_zero_dest", pk(RUN, NF, 0, 0));
        tick(); rs1_ex = 0; rs2_ex = 5; rd_mem = 5; rd_wb = 5;
                push(0, "fwd_b_mem_prio", pk(RUN, NF, 0, 0, 2'b00, 2'b10));
        tick(); reg_write_mem = 0; push(0, "fwd_b_wb", pk(RUN, NF, 0, 0, 2'b00, 2'b01));
        tick(); idle(); push(0, "idle0", pk(RUN, NF, 0, 0));

        // load-use
        tick(); mem_read_ex = 1; reg_write_ex = 1; rd_ex = 7; uses_rs2_id = 1; rs2_id = 7;
                push(0, "load_use_stall", pk(LU, F_LU, 0, 0));
        tick(); idle(); push(0, "load_use_release", pk(RUN, NF, 0, 1));
        tick(); mem_read_ex = 1; reg_write_ex = 1; rd_ex = 0; uses_rs2_id = 1; rs2_id = 0;
                push(0, "load_x0_no_stall", pk(RUN, NF, 0, 1));
        tick(); rd_ex = 7; rs2_id = 7; uses_rs2_id = 0; push(0, "load_unused_src", pk(RUN, NF, 0, 1));
        tick(); mem_read_ex = 0; uses_rs2_id = 1; push(0, "alu_producer_no_stall", pk(RUN, NF, 0, 1));
        tick(); idle(); push(0, "idle1", pk(RUN, NF, 0, 1));

        // two back-to-back multiplies
        for (int m = 0; m < 2; m++) begin
            tick(); is_mul_ex = 1; push(0, "mul_stall1", pk(MS, F_MS, 1, 32'(1 + 2 * m)));
            tick(); push(0, "mul_stall2", pk(MS, F_MS, 1, 32'(2 + 2 * m)));
            tick(); push(0, "mul_advance", pk(RUN, NF, 0, 32'(3 + 2 * m)));
        end
        tick(); idle(); push(0, "idle2", pk(RUN, NF, 0, 5));

        // branch on the first multiply cycle, then a fresh multiply must take the full latency
        tick(); is_mul_ex = 1; take_branch_mem = 1; push(0, "branch_over_mul", pk(RUN, F_BR, 0, 5));
        tick(); take_branch_mem = 0; push(0, "mul_after_flush_s1", pk(MS, F_MS, 1, 5));
        tick(); push(0, "mul_after_flush_s2", pk(MS, F_MS, 1, 6));
        tick(); push(0, "mul_after_flush_adv", pk(RUN, NF, 0, 7));
        tick(); idle(); push(0, "idle3", pk(RUN, NF, 0, 7));

        // enable dropped mid-multiply
        tick(); is_mul_ex = 1; push(0, "mul_before_drop", pk(MS, F_MS, 1, 7));
        tick(); enable = 0; push(0, "mul_drop_request", pk(MS, F_MS, 1, 8));
        tick(); push(0, "mul_paused", pk(OFF, NF, 0, 9));
        tick(); enable = 1; take_branch_mem = 1; push(0, "paused_branch_ignored", pk(OFF, NF, 0, 9));
        tick(); take_branch_mem = 0; push(0, "mul_resume_adv", pk(RUN, NF, 0, 9));
        tick(); idle(); push(0, "idle4", pk(RUN, NF, 0, 9));

        // asynchronous reset between edges, then the no-forwarding unit
        tick(); arst_n = 0;
                push(0, "async_reset_a", pk(OFF, NF, 0, 0));
                push(1, "async_reset_b", pk(OFF, NF, 0, 0));
        tick(); arst_n = 1; push(1, "nofwd_post_reset", pk(OFF, NF, 0, 0));
        tick(); push(1, "nofwd_run", pk(RUN, NF, 0, 0));
        tick(); uses_rs1_id = 1; rs1_id = 3; rd_ex = 3; reg_write_ex = 1;
                push(1, "raw_ex", pk(LU, F_LU, 0, 0));
                push(0, "fwd_alu_no_stall", pk(RUN, NF, 0, 0));
        tick(); rd_ex = 0; reg_write_ex = 0; rd_mem = 3; reg_write_mem = 1; rs1_ex = 3;
                push(1, "raw_mem", pk(LU, F_LU, 0, 1));
                push(0, "fwd_a_mem_b", pk(RUN, NF, 0, 0, 2'b10));
        tick(); rd_mem = 0; reg_write_mem = 0; rd_wb = 3; reg_write_wb = 1;
                push(1, "raw_wb", pk(LU, F_LU, 0, 2));
                push(0, "fwd_a_wb_b", pk(RUN, NF, 0, 0, 2'b01));
        tick(); idle(); push(1, "raw_release", pk(RUN, NF, 0, 3));
        tick(); uses_rs1_id = 1; rs1_id = 3; rd_ex = 3; reg_write_ex = 1;
                push(1, "raw_at_saturation", pk(LU, F_LU, 0, 3));
        tick(); idle(); push(1, "counter_saturated", pk(RUN, NF, 0, 3));
        tick(); is_mul_ex = 1; push(1, "mul_lat1_no_stall", pk(RUN, NF, 0, 3));
        tick(); idle(); push(1, "idle5", pk(RUN, NF, 0, 3));

        while (sb.size() > 0 && wait_c < 20) begin
            @(posedge clk);
            wait_c++;
        end
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
